// File: rtl/dcache_wb_buffer.sv
// Write-back buffer: queues dirty victim lines from the data cache and drains each one as
// an 8-beat AXI INCR burst, while still answering word lookups for lines not yet written.
module dcache_wb_buffer #(
  parameter int         DEPTH  = 2,
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         line_valid,
  output logic         line_ready,
  input  logic [31:0]  line_addr,
  input  logic [255:0] line_data,
  input  logic [31:0]  q_addr,
  output logic         q_hit,
  output logic [31:0]  q_data,
  output logic         empty,
  output logic [3:0]   m_awid,
  output logic [31:0]  m_awaddr,
  output logic [7:0]   m_awlen,
  output logic [2:0]   m_awsize,
  output logic [1:0]   m_awburst,
  output logic [1:0]   m_awlock,
  output logic [3:0]   m_awcache,
  output logic [2:0]   m_awprot,
  output logic         m_awvalid,
  input  logic         m_awready,
  output logic [3:0]   m_wid,
  output logic [31:0]  m_wdata,
  output logic [3:0]   m_wstrb,
  output logic         m_wlast,
  output logic         m_wvalid,
  input  logic         m_wready,
  input  logic         m_bvalid,
  output logic         m_bready
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [2:0]     beat_q, beat_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] match;
  logic [26:0]    tag_mem  [DEPTH];
  logic [255:0]   data_mem [DEPTH];
  logic [AW-1:0]  wr_idx, rd_idx, look_idx;
  logic           push, pop;
  logic           unused_bits;

  assign unused_bits = ^{line_addr[4:0], q_addr[1:0]};
  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign line_ready  = (count_q != (AW+1)'(DEPTH));
  assign push        = line_valid && line_ready;
  // The head entry is only released once the slave has acknowledged the whole burst.
  assign pop         = (state_q == S_RESP) && m_bvalid;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    valid_d  = valid_q;
    if (pop)  valid_d[rd_idx] = 1'b0;
    if (push) valid_d[wr_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_ADDR;
      S_ADDR: if (m_awready) begin
        state_d = S_DATA;
        beat_d  = 3'd0;
      end
      S_DATA: if (m_wready) begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = S_RESP;
      end
      S_RESP: if (m_bvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_idx]  <= line_addr[31:5];
      data_mem[wr_idx] <= line_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_q[gi] && (tag_mem[gi] == q_addr[31:5]);
  end

  // Scan oldest to youngest so the most recently pushed matching line wins.
  always_comb begin
    q_hit    = 1'b0;
    q_data   = 32'h0;
    look_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      look_idx = rd_idx + AW'(k);
      if (match[look_idx]) begin
        q_hit  = 1'b1;
        q_data = data_mem[look_idx][{q_addr[4:2], 5'b0} +: 32];
      end
    end
  end

  assign empty     = (count_q == '0) && (state_q == S_IDLE);
  assign m_awid    = AXI_ID;
  assign m_awaddr  = {tag_mem[rd_idx], 5'b0};
  assign m_awlen   = 8'd7;
  assign m_awsize  = 3'd2;
  assign m_awburst = 2'b01;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'd0;
  assign m_awprot  = 3'd0;
  assign m_awvalid = (state_q == S_ADDR);
  assign m_wid     = AXI_ID;
  assign m_wdata   = data_mem[rd_idx][{beat_q, 5'b0} +: 32];
  assign m_wstrb   = 4'b1111;
  assign m_wlast   = (state_q == S_DATA) && (beat_q == 3'd7);
  assign m_wvalid  = (state_q == S_DATA);
  assign m_bready  = (state_q == S_RESP);
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Directed bench for dcache_wb_buffer: pushes victim lines, plays an AXI write slave and
// checks burst contents, ordering, lookup and reset behaviour against hand-computed values.
module tb_dcache_wb_buffer;
  logic         clk = 1'b0;
  logic         rst;
  logic         line_valid, line_ready;
  logic [31:0]  line_addr;
  logic [255:0] line_data;
  logic [31:0]  q_addr;
  logic         q_hit;
  logic [31:0]  q_data;
  logic         empty;
  logic [3:0]   m_awid, m_awcache, m_wid, m_wstrb;
  logic [31:0]  m_awaddr, m_wdata;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize, m_awprot;
  logic [1:0]   m_awburst, m_awlock;
  logic         m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int checks = 0;
  int errors = 0;

  // Observations captured by drain_burst for the calling test to judge.
  logic [31:0] obs_addr;
  logic [7:0]  obs_awlen;
  logic [31:0] obs_words [8];
  logic [7:0]  obs_wlast;
  int          obs_beats, obs_stable_err;
  logic        obs_timeout, obs_early_w, obs_hit_all, obs_wv_after, obs_bready;

  always #5 clk = ~clk;

  dcache_wb_buffer #(.DEPTH(2), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .line_valid(line_valid), .line_ready(line_ready), .line_addr(line_addr), .line_data(line_data),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .empty(empty),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + step * k;
    return r;
  endfunction

  task automatic push_line(input logic [31:0] addr, input logic [255:0] data);
    line_valid = 1'b1;
    line_addr  = addr;
    line_data  = data;
    tick();
    line_valid = 1'b0;
  endtask

  // Acts as the AXI slave for one burst; stall bit (cycle%8) set means wready low that cycle.
  task automatic drain_burst(input logic [7:0] stall);
    int guard;
    logic [31:0] pd;
    logic pl;
    obs_timeout = 1'b0; obs_beats = 0; obs_wlast = 8'h0; obs_stable_err = 0;
    obs_early_w = 1'b0; obs_hit_all = 1'b1;
    guard = 0;
    while (!m_awvalid && guard < 20) begin
      if (m_wvalid) obs_early_w = 1'b1;
      tick();
      guard++;
    end
    if (!m_awvalid) begin
      obs_timeout = 1'b1;
      return;
    end
    obs_addr  = m_awaddr;
    obs_awlen = m_awlen;
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    guard = 0;
    while (obs_beats < 8 && guard < 100) begin
      obs_hit_all &= q_hit;
      if (m_wvalid) begin
        m_wready = !stall[guard % 8];
        if (m_wready) begin
          obs_words[obs_beats] = m_wdata;
          obs_wlast[obs_beats] = m_wlast;
          obs_beats++;
          tick();
        end else begin
          pd = m_wdata;
          pl = m_wlast;
          tick();
          if (m_wdata !== pd || m_wlast !== pl) obs_stable_err++;
        end
      end else begin
        tick();
      end
      guard++;
    end
    m_wready     = 1'b0;
    obs_wv_after = m_wvalid;
    obs_bready   = m_bready;
    obs_hit_all &= q_hit;
    m_bvalid = 1'b1;
    tick();
    m_bvalid = 1'b0;
    $display("burst addr=%08h beats=%0d w0=%08h w7=%08h", obs_addr, obs_beats, obs_words[0], obs_words[7]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL rst_line_ready got %0h exp 1", line_ready); end
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL rst_q_hit got %0h exp 0", q_hit); end
    checks++; if (q_data !== 32'h0) begin errors++; $display("FAIL rst_q_data got %0h exp 0", q_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0h exp 1", empty); end
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %0h exp 0", m_awvalid); end
    checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %0h exp 0", m_wvalid); end
    checks++; if (m_wlast !== 1'b0) begin errors++; $display("FAIL rst_wlast got %0h exp 0", m_wlast); end
    checks++; if (m_bready !== 1'b0) begin errors++; $display("FAIL rst_bready got %0h exp 0", m_bready); end
    checks++; if ({m_awid, m_wid, m_awsize, m_awburst, m_wstrb} !== {4'd1, 4'd1, 3'd2, 2'b01, 4'hF}) begin
      errors++; $display("FAIL rst_axi_consts got %0h exp %0h", {m_awid, m_wid, m_awsize, m_awburst, m_wstrb}, {4'd1, 4'd1, 3'd2, 2'b01, 4'hF});
    end
    $display("reset done");
  endtask

  task automatic test_single_burst();
    push_line(32'h0000_1040, mk_line(32'h11, 32'h11));
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL single_aw_early got %0h exp 0", m_awvalid); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty got %0h exp 0", empty); end
    tick();
    checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL single_aw_latency got %0h exp 1", m_awvalid); end
    drain_burst(8'h00);
    checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout got %0h exp 0", obs_timeout); end
    checks++; if (obs_early_w !== 1'b0) begin errors++; $display("FAIL single_w_before_aw got %0h exp 0", obs_early_w); end
    checks++; if (obs_addr !== 32'h0000_1040) begin errors++; $display("FAIL single_awaddr got %0h exp 1040", obs_addr); end
    checks++; if (obs_awlen !== 8'd7) begin errors++; $display("FAIL single_awlen got %0h exp 7", obs_awlen); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (obs_words[k] !== 32'h11 * (k + 1)) begin errors++; $display("FAIL single_wdata[%0d] got %0h exp %0h", k, obs_words[k], 32'h11 * (k + 1)); end
    end
    checks++; if (obs_wlast !== 8'h80) begin errors++; $display("FAIL single_wlast_mask got %0h exp 80", obs_wlast); end
    checks++; if (obs_bready !== 1'b1) begin errors++; $display("FAIL single_bready got %0h exp 1", obs_bready); end
    checks++; if (obs_wv_after !== 1'b0) begin errors++; $display("FAIL single_extra_beat got %0h exp 0", obs_wv_after); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after got %0h exp 1", empty); end
  endtask

  task automatic test_full_order();
    push_line(32'h0000_1040, mk_line(32'h11, 32'h11));
    checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL full_ready_one got %0h exp 1", line_ready); end
    push_line(32'h0000_2080, mk_line(32'hB0, 32'h1));
    checks++; if (line_ready !== 1'b0) begin errors++; $display("FAIL full_ready_two got %0h exp 0", line_ready); end
    push_line(32'h0000_3000, mk_line(32'hC0, 32'h1));
    checks++; if (line_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold got %0h exp 0", line_ready); end
    q_addr = 32'h0000_3000;
    #1;
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL full_dropped_push got %0h exp 0", q_hit); end
    checks++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h0000_1040) begin
      errors++; $display("FAIL full_aw_held got %0h/%0h exp 1/1040", m_awvalid, m_awaddr);
    end
    drain_burst(8'h00);
    checks++; if (obs_addr !== 32'h0000_1040 || obs_words[0] !== 32'h11 || obs_words[7] !== 32'h88) begin
      errors++; $display("FAIL full_first_burst got %0h %0h %0h exp 1040 11 88", obs_addr, obs_words[0], obs_words[7]);
    end
    checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_b got %0h exp 1", line_ready); end
    drain_burst(8'h00);
    checks++; if (obs_addr !== 32'h0000_2080 || obs_words[0] !== 32'hB0 || obs_words[7] !== 32'hB7) begin
      errors++; $display("FAIL full_second_burst got %0h %0h %0h exp 2080 b0 b7", obs_addr, obs_words[0], obs_words[7]);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty_after got %0h exp 1", empty); end
  endtask

  task automatic test_lookup();
    q_addr     = 32'h0000_1048;
    line_valid = 1'b1;
    line_addr  = 32'h0000_104C;
    line_data  = mk_line(32'h11, 32'h11);
    #1;
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL lookup_no_bypass got %0h exp 0", q_hit); end
    tick();
    line_valid = 1'b0;
    checks++; if (q_hit !== 1'b1 || q_data !== 32'h33) begin errors++; $display("FAIL lookup_hit got %0h/%0h exp 1/33", q_hit, q_data); end
    q_addr = 32'h0000_1060;
    #1;
    checks++; if (q_hit !== 1'b0 || q_data !== 32'h0) begin errors++; $display("FAIL lookup_other_line got %0h/%0h exp 0/0", q_hit, q_data); end
    q_addr = 32'h0000_1048;
    drain_burst(8'h00);
    checks++; if (obs_addr !== 32'h0000_1040) begin errors++; $display("FAIL lookup_addr_masked got %0h exp 1040", obs_addr); end
    checks++; if (obs_hit_all !== 1'b1) begin errors++; $display("FAIL lookup_hit_during_drain got %0h exp 1", obs_hit_all); end
    checks++; if (q_hit !== 1'b0 || q_data !== 32'h0) begin errors++; $display("FAIL lookup_after_b got %0h/%0h exp 0/0", q_hit, q_data); end
  endtask

  task automatic test_youngest();
    push_line(32'h0000_1040, mk_line(32'h11, 32'h11));
    push_line(32'h0000_1040, mk_line(32'hA0, 32'h1));
    q_addr = 32'h0000_1040;
    #1;
    checks++; if (q_hit !== 1'b1 || q_data !== 32'hA0) begin errors++; $display("FAIL young_word0 got %0h/%0h exp 1/a0", q_hit, q_data); end
    q_addr = 32'h0000_105C;
    #1;
    checks++; if (q_data !== 32'hA7) begin errors++; $display("FAIL young_word7 got %0h exp a7", q_data); end
    drain_burst(8'h00);
    checks++; if (obs_words[2] !== 32'h33) begin errors++; $display("FAIL young_old_drained got %0h exp 33", obs_words[2]); end
    checks++; if (q_hit !== 1'b1 || q_data !== 32'hA7) begin errors++; $display("FAIL young_after_pop got %0h/%0h exp 1/a7", q_hit, q_data); end
    drain_burst(8'h00);
    checks++; if (obs_words[5] !== 32'hA5) begin errors++; $display("FAIL young_new_drained got %0h exp a5", obs_words[5]); end
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL young_gone got %0h exp 0", q_hit); end
  endtask

  task automatic test_wready_stall();
    push_line(32'h0000_4000, mk_line(32'hD0, 32'h1));
    drain_burst(8'b0101_1011);
    checks++; if (obs_beats !== 8) begin errors++; $display("FAIL stall_beats got %0d exp 8", obs_beats); end
    checks++; if (obs_stable_err !== 0) begin errors++; $display("FAIL stall_stable got %0d exp 0", obs_stable_err); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (obs_words[k] !== 32'hD0 + k) begin errors++; $display("FAIL stall_wdata[%0d] got %0h exp %0h", k, obs_words[k], 32'hD0 + k); end
    end
    checks++; if (obs_wlast !== 8'h80) begin errors++; $display("FAIL stall_wlast_mask got %0h exp 80", obs_wlast); end
    checks++; if (obs_wv_after !== 1'b0) begin errors++; $display("FAIL stall_extra_beat got %0h exp 0", obs_wv_after); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stall_empty_after got %0h exp 1", empty); end
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    push_line(32'h0000_5000, mk_line(32'hE0, 32'h1));
    push_line(32'h0000_6000, mk_line(32'hF0, 32'h1));
    guard = 0;
    while (!m_awvalid && guard < 20) begin tick(); guard++; end
    checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL midrst_aw_wait got %0h exp 1", m_awvalid); end
    m_awready = 1'b1;
    tick();
    m_awready = 1'b0;
    m_wready  = 1'b1;
    repeat (4) tick();
    m_wready = 1'b0;
    checks++; if (m_wvalid !== 1'b1 || m_wdata !== 32'hE4) begin errors++; $display("FAIL midrst_beat4 got %0h/%0h exp 1/e4", m_wvalid, m_wdata); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0) begin errors++; $display("FAIL midrst_valids got %0h/%0h exp 0/0", m_awvalid, m_wvalid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %0h exp 1", empty); end
    checks++; if (line_ready !== 1'b1) begin errors++; $display("FAIL midrst_line_ready got %0h exp 1", line_ready); end
    q_addr = 32'h0000_5000;
    repeat (3) tick();
    checks++; if (q_hit !== 1'b0 || m_awvalid !== 1'b0) begin errors++; $display("FAIL midrst_dropped got %0h/%0h exp 0/0", q_hit, m_awvalid); end
    $display("reset mid-burst done");
  endtask

  initial begin
    rst = 1'b1; line_valid = 1'b0; line_addr = '0; line_data = '0; q_addr = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    test_reset();
    test_single_burst();
    test_full_order();
    test_lookup();
    test_youngest();
    test_wready_stall();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
